jump_stack_controller: RTL and testbench
========================================

# jump_stack_controller

Branch/jump resolution unit for the pipelined core with an integrated, parametrised return-address stack (RAS). It decodes the ID-stage opcode using the `defines.sv` jump macros and drives the PC-source one-hot selects and the PR1 flush. It also owns the JSB/RET stack storage, with configurable depth, PC width and overflow policy, plus sticky error reporting. It sits between the ID stage and the PC mux, which takes its return target from `ret_addr`.

## Interface
- `PC_W`, 12, PC/return-address width in bits.
- `DEPTH`, 8, RAS entries; power of two, ≥2.
- `WRAP_ON_OVF`, 0, overflow policy: 0 = drop push (saturate), 1 = overwrite oldest entry (circular).

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: ID-stage opcode.
- `z_out` in 1: zero flag for BZ/BNZ.
- `PR2_jump_en` in 1: jump already taken in the next stage; suppresses all decode this cycle.
- `stall` in 1: pipeline hold; suppresses all decode and stack updates this cycle.
- `pc_plus1` in PC_W: return address pushed by JSB.
- `clr_err` in 1: clears the sticky error flags.
- `sel_PC_src_plus1`, `sel_PC_src_offset`, `sel_PC_src_const`, `sel_PC_src_stack` out 1 each: one-hot PC source.
- `flush_PR1` out 1: flush the IF/ID register.
- `ret_addr` out PC_W: current top of stack; 0 when empty.
- `ras_count` out $clog2(DEPTH+1): number of valid entries.
- `ras_overflow`, `ras_underflow` out 1: sticky error flags.

## Operation
- Decode is active only when `!PR2_jump_en && !stall`. When inactive: `sel_PC_src_plus1`=1, all other selects and `flush_PR1` are 0, and no stack update occurs.
- Conditional jump type (`opcode[5:3]`):
  - `BZ_FN` with `z_out`=1, or `BNZ_FN` with `z_out`=0: offset select and flush.
  - Otherwise: plus1 select.
- Non-conditional type (`opcode[5:2]`): const select and flush. If `opcode[5:1]==JSB_OPCODE`, push `pc_plus1`.
- `opcode==OTHER_TYPE_OPCODE` (RET): stack select, flush, pop.
- Storage is a circular buffer of DEPTH×PC_W with write pointer `wp` (log2 DEPTH bits).
  - Top entry is `mem[wp-1]` (mod DEPTH).
  - `ret_addr` = top entry when `ras_count`>0, else 0.
- Push with count<DEPTH: write `mem[wp]`, `wp`+1, count+1.
- Push with count==DEPTH:
  - `WRAP_ON_OVF`=0: no write, pointer and count unchanged; set `ras_overflow`.
  - `WRAP_ON_OVF`=1: write `mem[wp]` over the oldest entry, `wp`+1, count stays DEPTH; set `ras_overflow`.
- Pop with count>0: `wp`-1, count-1. Entry contents are left in place.
- Pop with count==0: PC still selects stack (`ret_addr`=0); pointer and count unchanged; set `ras_underflow`.
- Push and pop never coincide, since they come from distinct opcodes.
- Error flags stay set until `clr_err` or `rst`. If `clr_err` and a new error occur in the same cycle, the error wins (flag reads 1).
- Pointer arithmetic wraps modulo DEPTH. Count is saturating and never exceeds DEPTH or goes below 0.

## Timing
- Selects and `flush_PR1` are combinational from opcode/`z_out`/`PR2_jump_en`/`stall`, valid in the same cycle.
- `ret_addr` is combinational from registered state. A RET reads the pre-pop top in its own cycle; the pop takes effect at the next edge.
- A JSB push is visible on `ret_addr` one cycle after the JSB cycle. Back-to-back JSB then RET returns the just-pushed address.
- Reset values:
  - `wp`=0, `ras_count`=0, both flags 0, `ret_addr`=0.
  - Selects follow decode. During `rst`, stack updates are blocked; combinational outputs still decode.
- Storage contents need not be reset; they are masked by count.
- Asserting `rst` mid-sequence discards all entries at that edge. A RET in the cycle after reset sees an empty stack and raises underflow.

## Test plan
- JSB with `pc_plus1`=0x010, then RET two cycles later → `sel_PC_src_stack`=1, `flush_PR1`=1, `ret_addr`=0x010; count goes 0→1→0.
- BZ with `z_out`=1 → offset select and flush. BNZ with `z_out`=1 → plus1 only. Repeat both with `PR2_jump_en`=1 → plus1 only, no flush.
- DEPTH=8, WRAP_ON_OVF=0: 9 JSBs pushing 0x001..0x009 → count=8, `ras_overflow`=1; 8 RETs return 0x008..0x001.
- Same sequence with WRAP_ON_OVF=1 → 8 RETs return 0x009..0x002; count ends at 0.
- RET on an empty stack → `ret_addr`=0, `ras_underflow`=1, count stays 0. `clr_err` pulse → flag 0. `clr_err` asserted together with another empty RET → flag stays 1.
- JSB while `stall`=1 → no count change, plus1 only. Push 3 entries, then assert `rst` → count=0, flags=0, `ret_addr`=0.

Source files
------------

// File: rtl/jump_stack_controller.sv
// Jump/branch resolution with PC-source one-hot selects and PR1 flush.
// Owns the JSB/RET return-address stack with sticky overflow/underflow flags.
module jump_stack_controller #(
    parameter int PC_W        = 12,
    parameter int DEPTH       = 8,
    parameter bit WRAP_ON_OVF = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 opcode,
    input  logic                       z_out,
    input  logic                       PR2_jump_en,
    input  logic                       stall,
    input  logic [PC_W-1:0]            pc_plus1,
    input  logic                       clr_err,
    output logic                       sel_PC_src_plus1,
    output logic                       sel_PC_src_offset,
    output logic                       sel_PC_src_const,
    output logic                       sel_PC_src_stack,
    output logic                       flush_PR1,
    output logic [PC_W-1:0]            ret_addr,
    output logic [$clog2(DEPTH+1)-1:0] ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Jump opcode encodings shared with the decoder.
    localparam logic [2:0] BZ_FN             = 3'b100;
    localparam logic [2:0] BNZ_FN            = 3'b101;
    localparam logic [3:0] NON_COND_TYPE     = 4'b1100;
    localparam logic [4:0] JSB_OPCODE        = 5'b11001;
    localparam logic [5:0] OTHER_TYPE_OPCODE = 6'b111000;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    logic active;
    logic is_bz, is_bnz, is_ncond, is_ret;
    logic push_req, pop_req;
    logic do_push, do_pop;
    logic full, empty;
    logic mem_we;
    logic ovf_evt, udf_evt;
    logic [AW-1:0] top_idx;

    assign active   = !PR2_jump_en && !stall;
    assign is_bz    = (opcode[5:3] == BZ_FN);
    assign is_bnz   = (opcode[5:3] == BNZ_FN);
    assign is_ncond = (opcode[5:2] == NON_COND_TYPE);
    assign is_ret   = (opcode == OTHER_TYPE_OPCODE);

    // Select/flush decode; the four classes are mutually exclusive.
    always_comb begin
        sel_PC_src_plus1  = 1'b1;
        sel_PC_src_offset = 1'b0;
        sel_PC_src_const  = 1'b0;
        sel_PC_src_stack  = 1'b0;
        flush_PR1         = 1'b0;
        push_req          = 1'b0;
        pop_req           = 1'b0;
        if (active) begin
            unique case (1'b1)
                is_bz, is_bnz: begin
                    if ((is_bz && z_out) || (is_bnz && !z_out)) begin
                        sel_PC_src_plus1  = 1'b0;
                        sel_PC_src_offset = 1'b1;
                        flush_PR1         = 1'b1;
                    end
                end
                is_ncond: begin
                    sel_PC_src_plus1 = 1'b0;
                    sel_PC_src_const = 1'b1;
                    flush_PR1        = 1'b1;
                    push_req         = (opcode[5:1] == JSB_OPCODE);
                end
                is_ret: begin
                    sel_PC_src_plus1 = 1'b0;
                    sel_PC_src_stack = 1'b1;
                    flush_PR1        = 1'b1;
                    pop_req          = 1'b1;
                end
                default: begin
                    sel_PC_src_plus1 = 1'b1;
                end
            endcase
        end
    end

    assign do_push = push_req && !rst;
    assign do_pop  = pop_req && !rst;
    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);

    always_comb begin
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;
        if (do_push) begin
            if (!full) begin
                mem_we = 1'b1;
                wp_d   = wp_q + AW'(1);
                cnt_d  = cnt_q + CW'(1);
            end else begin
                ovf_evt = 1'b1;
                if (WRAP_ON_OVF) begin
                    mem_we = 1'b1;
                    wp_d   = wp_q + AW'(1);
                end
            end
        end else if (do_pop) begin
            if (!empty) begin
                wp_d  = wp_q - AW'(1);
                cnt_d = cnt_q - CW'(1);
            end else begin
                udf_evt = 1'b1;
            end
        end
    end

    // A fresh error in the clearing cycle must stay visible.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (ovf_evt) ovf_d = 1'b1;
        if (udf_evt) udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wp_q] <= pc_plus1;
        end
    end

    assign top_idx       = wp_q - AW'(1);
    assign ret_addr      = empty ? '0 : mem_q[top_idx];
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = udf_q;

endmodule

// File: tb/tb_jump_stack_controller.sv
// Directed bench for jump_stack_controller: saturating and wrapping
// instances driven in lockstep and checked against a queue-based model.
module tb_jump_stack_controller;

    localparam logic [5:0] NOP = 6'b000000;
    localparam logic [5:0] BZ  = 6'b100000;
    localparam logic [5:0] BNZ = 6'b101000;
    localparam logic [5:0] JMP = 6'b110000;
    localparam logic [5:0] JSB = 6'b110010;
    localparam logic [5:0] RET = 6'b111000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        z_out;
    logic        PR2_jump_en;
    logic        stall;
    logic [11:0] pc_plus1;
    logic        clr_err;

    logic        p0, o0, c0, s0, f0, ovf0, udf0;
    logic [11:0] ra0;
    logic [3:0]  cnt0;
    logic        p1, o1, c1, s1, f1, ovf1, udf1;
    logic [11:0] ra1;
    logic [3:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  sel;
        logic        flush;
        logic [11:0] ra0, ra1;
        logic [3:0]  c0, c1;
        logic        ov0, ov1, un0, un1;
    } exp_t;

    exp_t sb[$];
    logic [11:0] m0[$];
    logic [11:0] m1[$];
    logic mov0, mov1, mun0, mun1;

    always #5 clk = ~clk;

    jump_stack_controller #(.PC_W(12), .DEPTH(8), .WRAP_ON_OVF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .z_out(z_out),
        .PR2_jump_en(PR2_jump_en), .stall(stall), .pc_plus1(pc_plus1),
        .clr_err(clr_err),
        .sel_PC_src_plus1(p0), .sel_PC_src_offset(o0),
        .sel_PC_src_const(c0), .sel_PC_src_stack(s0),
        .flush_PR1(f0), .ret_addr(ra0), .ras_count(cnt0),
        .ras_overflow(ovf0), .ras_underflow(udf0)
    );

    jump_stack_controller #(.PC_W(12), .DEPTH(8), .WRAP_ON_OVF(1'b1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .z_out(z_out),
        .PR2_jump_en(PR2_jump_en), .stall(stall), .pc_plus1(pc_plus1),
        .clr_err(clr_err),
        .sel_PC_src_plus1(p1), .sel_PC_src_offset(o1),
        .sel_PC_src_const(c1), .sel_PC_src_stack(s1),
        .flush_PR1(f1), .ret_addr(ra1), .ras_count(cnt1),
        .ras_overflow(ovf1), .ras_underflow(udf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic z,
                        input logic pr2, input logic stl,
                        input logic [11:0] pc, input logic clr,
                        input logic rs, input string tag);
        exp_t e, g;
        logic act, push, pop;
        logic eo0, eo1, eu0, eu1;
        opcode      = op;
        z_out       = z;
        PR2_jump_en = pr2;
        stall       = stl;
        pc_plus1    = pc;
        clr_err     = clr;
        rst         = rs;
        act  = !pr2 && !stl;
        push = 1'b0;
        pop  = 1'b0;
        e.sel   = 4'b1000;
        e.flush = 1'b0;
        if (act) begin
            casez (op)
                6'b100???: if (z)  begin e.sel = 4'b0100; e.flush = 1'b1; end
                6'b101???: if (!z) begin e.sel = 4'b0100; e.flush = 1'b1; end
                6'b11000?: begin e.sel = 4'b0010; e.flush = 1'b1; end
                6'b11001?: begin e.sel = 4'b0010; e.flush = 1'b1; push = 1'b1; end
                6'b111000: begin e.sel = 4'b0001; e.flush = 1'b1; pop = 1'b1; end
                default: ;
            endcase
        end
        e.ra0 = (m0.size() > 0) ? m0[$] : 12'h0;
        e.ra1 = (m1.size() > 0) ? m1[$] : 12'h0;
        e.c0  = 4'(m0.size());
        e.c1  = 4'(m1.size());
        e.ov0 = mov0;
        e.ov1 = mov1;
        e.un0 = mun0;
        e.un1 = mun1;
        sb.push_back(e);
        #4;
        g = sb.pop_front();
        chk({tag, ".sel0"},  {28'h0, p0, o0, c0, s0}, {28'h0, g.sel});
        chk({tag, ".sel1"},  {28'h0, p1, o1, c1, s1}, {28'h0, g.sel});
        chk({tag, ".flush"}, {31'h0, f0 & f1},        {31'h0, g.flush});
        chk({tag, ".ra0"},   {20'h0, ra0},            {20'h0, g.ra0});
        chk({tag, ".ra1"},   {20'h0, ra1},            {20'h0, g.ra1});
        chk({tag, ".cnt0"},  {28'h0, cnt0},           {28'h0, g.c0});
        chk({tag, ".cnt1"},  {28'h0, cnt1},           {28'h0, g.c1});
        chk({tag, ".ovf0"},  {31'h0, ovf0},           {31'h0, g.ov0});
        chk({tag, ".ovf1"},  {31'h0, ovf1},           {31'h0, g.ov1});
        chk({tag, ".udf0"},  {31'h0, udf0},           {31'h0, g.un0});
        chk({tag, ".udf1"},  {31'h0, udf1},           {31'h0, g.un1});
        if (rs) begin
            m0.delete();
            m1.delete();
            mov0 = 0; mov1 = 0; mun0 = 0; mun1 = 0;
        end else begin
            eo0 = 0; eo1 = 0; eu0 = 0; eu1 = 0;
            if (push) begin
                if (m0.size() < 8) m0.push_back(pc);
                else eo0 = 1;
                if (m1.size() == 8) begin
                    eo1 = 1;
                    void'(m1.pop_front());
                end
                m1.push_back(pc);
            end
            if (pop) begin
                if (m0.size() > 0) void'(m0.pop_back());
                else eu0 = 1;
                if (m1.size() > 0) void'(m1.pop_back());
                else eu1 = 1;
            end
            if (clr) begin
                mov0 = 0; mov1 = 0; mun0 = 0; mun1 = 0;
            end
            if (eo0) mov0 = 1;
            if (eo1) mov1 = 1;
            if (eu0) mun0 = 1;
            if (eu1) mun1 = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op1(input logic [5:0] op, input logic [11:0] pc,
                       input string tag);
        step(op, 1'b0, 1'b0, 1'b0, pc, 1'b0, 1'b0, tag);
    endtask

    initial begin
        mov0 = 0; mov1 = 0; mun0 = 0; mun1 = 0;
        opcode = NOP; z_out = 0; PR2_jump_en = 0; stall = 0;
        pc_plus1 = 0; clr_err = 0; rst = 1;
        @(posedge clk);
        #1;
        step(NOP, 0, 0, 0, 12'h0, 0, 1, "rst_hold");
        step(JSB, 0, 0, 0, 12'h3AA, 0, 1, "jsb_in_rst");
        op1(NOP, 12'h0, "idle");

        op1(JSB, 12'h010, "jsb10");
        op1(NOP, 12'h0, "after_jsb");
        op1(RET, 12'h0, "ret10");
        op1(NOP, 12'h0, "after_ret");

        step(BZ,  1, 0, 0, 12'h0, 0, 0, "bz_z1");
        step(BZ,  0, 0, 0, 12'h0, 0, 0, "bz_z0");
        step(BNZ, 1, 0, 0, 12'h0, 0, 0, "bnz_z1");
        step(BNZ, 0, 0, 0, 12'h0, 0, 0, "bnz_z0");
        step(BZ,  1, 1, 0, 12'h0, 0, 0, "bz_pr2");
        step(BNZ, 0, 1, 0, 12'h0, 0, 0, "bnz_pr2");
        op1(JMP, 12'h055, "jmp");
        step(RET, 0, 1, 0, 12'h0, 0, 0, "ret_pr2");

        for (int i = 1; i <= 9; i++) op1(JSB, 12'(i), "fill");
        op1(NOP, 12'h0, "full");
        for (int i = 0; i < 8; i++) op1(RET, 12'h0, "drain");
        op1(RET, 12'h0, "ret_empty");
        op1(NOP, 12'h0, "udf_sticky");
        step(NOP, 0, 0, 0, 12'h0, 1, 0, "clr");
        op1(NOP, 12'h0, "cleared");
        step(RET, 0, 0, 0, 12'h0, 1, 0, "clr_and_udf");
        op1(NOP, 12'h0, "udf_wins");
        step(NOP, 0, 0, 0, 12'h0, 1, 0, "clr2");

        step(JSB, 0, 0, 1, 12'h123, 0, 0, "jsb_stall");
        step(RET, 0, 0, 1, 12'h0, 0, 0, "ret_stall");
        op1(JSB, 12'h0A1, "p1");
        op1(JSB, 12'h0A2, "p2");
        op1(RET, 12'h0, "ret_b2b");
        op1(JSB, 12'h0A3, "p3");
        op1(JSB, 12'h0A4, "p4");
        step(NOP, 0, 0, 0, 12'h0, 0, 1, "mid_rst");
        op1(RET, 12'h0, "ret_post_rst");
        op1(NOP, 12'h0, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
